// File: rtl/typedef_pkg.sv
// Shared types for the vector instruction queue: one queued entry and the default depth.
package typedef_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  sew;
    } vec_entry_t;

    localparam int unsigned ENTRY_W = $bits(vec_entry_t);

endpackage

// File: rtl/vector_instr_fifo_mem.sv
// Entry storage for the vector instruction queue: one synchronous write port, one async read port.
module vector_instr_fifo_mem
    import typedef_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  vec_entry_t    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output vec_entry_t    rdata_o
);

    // Contents are deliberately not reset; the pointers alone define what is valid.
    vec_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vector_instr_queue.sv
// Decoupling FIFO between the scalar core and the vector scheduler; pointer and count control live here.
module vector_instr_queue
    import typedef_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       instr_vld_i,
    input  logic [31:0]                vector_instr_i,
    input  logic [31:0]                rs1_i,
    input  logic [31:0]                rs2_i,
    input  logic [1:0]                 sew_i,
    output logic                       instr_rdy_o,
    output logic [31:0]                vector_instr_o,
    output logic [31:0]                rs1_o,
    output logic [31:0]                rs2_o,
    output logic [1:0]                 sew_o,
    input  logic                       vector_stall_i,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          empty, full, push, pop;
    vec_entry_t    wr_entry, rd_entry, head;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == CW'(DEPTH));

    // Push is gated only by stored state, so a pop in the same cycle never frees a full slot early.
    assign push = instr_vld_i && !full;
    assign pop  = !empty && !vector_stall_i;

    assign wr_entry = '{instr: vector_instr_i, rs1: rs1_i, rs2: rs2_i, sew: sew_i};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    vector_instr_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // An empty queue presents an all-zero entry, which the scheduler reads as "no instruction".
    assign head = empty ? '0 : rd_entry;

    assign vector_instr_o = head.instr;
    assign rs1_o          = head.rs1;
    assign rs2_o          = head.rs2;
    assign sew_o          = head.sew;
    assign instr_rdy_o    = !full;
    assign occupancy_o    = occ_q;
    assign empty_o        = empty;
    assign full_o         = full;

endmodule

// File: tb/tb_vector_instr_queue.sv
// Randomized and directed bench for vector_instr_queue against a queue-based reference model.
module tb_vector_instr_queue;
    import typedef_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        instr_vld_i;
    logic [31:0] vector_instr_i, rs1_i, rs2_i;
    logic [1:0]  sew_i;
    logic        instr_rdy_o;
    logic [31:0] vector_instr_o, rs1_o, rs2_o;
    logic [1:0]  sew_o;
    logic        vector_stall_i;
    logic [$clog2(DEPTH):0] occupancy_o;
    logic        empty_o, full_o;

    vec_entry_t model_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vector_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .instr_vld_i    (instr_vld_i),
        .vector_instr_i (vector_instr_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .sew_i          (sew_i),
        .instr_rdy_o    (instr_rdy_o),
        .vector_instr_o (vector_instr_o),
        .rs1_o          (rs1_o),
        .rs2_o          (rs2_o),
        .sew_o          (sew_o),
        .vector_stall_i (vector_stall_i),
        .occupancy_o    (occupancy_o),
        .empty_o        (empty_o),
        .full_o         (full_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic vec_entry_t rand_entry();
        vec_entry_t e;
        e.instr = $urandom;
        e.rs1   = $urandom;
        e.rs2   = $urandom;
        e.sew   = 2'($urandom_range(0, 3));
        return e;
    endfunction

    task automatic check_state(input string tag);
        vec_entry_t h;
        int         n;
        n = model_q.size();
        h = (n > 0) ? model_q[0] : '0;
        chk({tag, ".occ"},   128'(occupancy_o), 128'(n));
        chk({tag, ".empty"}, 128'(empty_o),     128'(n == 0));
        chk({tag, ".full"},  128'(full_o),      128'(n == DEPTH));
        chk({tag, ".rdy"},   128'(instr_rdy_o), 128'(n < DEPTH));
        chk({tag, ".head"},  {30'b0, vector_instr_o, rs1_o, rs2_o, sew_o}, 128'(h));
    endtask

    // One clock: drive inputs at the falling edge, check, then advance the model on the rising edge.
    task automatic cycle(input logic vld, input vec_entry_t e, input logic stall);
        bit push, pop;
        instr_vld_i    = vld;
        vector_instr_i = e.instr;
        rs1_i          = e.rs1;
        rs2_i          = e.rs2;
        sew_i          = e.sew;
        vector_stall_i = ~stall;
        #1;
        chk("rdy_vs_stall", 128'(instr_rdy_o), 128'(model_q.size() < DEPTH));
        vector_stall_i = stall;
        #1;
        check_state("cyc");
        push = vld && (model_q.size() < DEPTH);
        pop  = (model_q.size() > 0) && !stall;
        @(posedge clk);
        if (pop)  void'(model_q.pop_front());
        if (push) model_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && model_q.size() > 0; i++) cycle(1'b0, '0, 1'b0);
        chk("drain_empty", 128'(empty_o), 128'(1));
    endtask

    initial begin
        vec_entry_t e;
        rstn = 1'b0;
        instr_vld_i = 1'b0; vector_instr_i = '0; rs1_i = '0; rs2_i = '0; sew_i = '0;
        vector_stall_i = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst.empty", 128'(empty_o), 128'(1));
        chk("rst.rdy",   128'(instr_rdy_o), 128'(1));
        chk("rst.full",  128'(full_o), 128'(0));
        chk("rst.instr", 128'(vector_instr_o), 128'(0));
        chk("rst.occ",   128'(occupancy_o), 128'(0));
        @(negedge clk);
        rstn = 1'b1;

        // Single instruction: one cycle to head, popped on the following edge.
        e = '{instr: 32'h0205_7007, rs1: 32'h1000, rs2: 32'h0, sew: 2'b10};
        cycle(1'b1, e, 1'b0);
        chk("single.head", 128'(vector_instr_o), 128'(32'h0205_7007));
        chk("single.rs1",  128'(rs1_o), 128'(32'h1000));
        chk("single.sew",  128'(sew_o), 128'(2'b10));
        cycle(1'b0, '0, 1'b0);
        chk("single.empty", 128'(empty_o), 128'(1));

        // Overfill under stall; the fifth offer waits until a pop has happened.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_entry(), 1'b1);
        e = rand_entry();
        cycle(1'b1, e, 1'b1);
        cycle(1'b1, e, 1'b0);
        chk("full.after_pop", 128'(occupancy_o), 128'(DEPTH - 1));
        cycle(1'b1, e, 1'b1);
        chk("full.refill", 128'(occupancy_o), 128'(DEPTH));
        drain();

        // Steady push+pop at occupancy 2 across pointer wrap.
        cycle(1'b1, rand_entry(), 1'b1);
        cycle(1'b1, rand_entry(), 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, rand_entry(), 1'b0);
        chk("steady.occ", 128'(occupancy_o), 128'(2));
        drain();

        // Asynchronous reset with entries pending.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_entry(), 1'b1);
        instr_vld_i = 1'b0;
        #2 rstn = 1'b0;
        #1;
        model_q.delete();
        check_state("midrst");
        @(negedge clk);
        rstn = 1'b1;
        e = '{instr: 32'h0000_0057, rs1: 32'h0, rs2: 32'h0, sew: 2'b00};
        cycle(1'b1, e, 1'b1);
        chk("postrst.head", 128'(vector_instr_o), 128'(32'h0000_0057));
        chk("postrst.occ",  128'(occupancy_o), 128'(1));
        drain();

        // Random traffic in phases of differing push/stall pressure.
        for (int ph = 0; ph < 10; ph++) begin
            int pv, ps;
            pv = $urandom_range(20, 90);
            ps = $urandom_range(10, 80);
            for (int i = 0; i < 1000; i++) begin
                cycle(($urandom_range(0, 99) < pv), rand_entry(), ($urandom_range(0, 99) < ps));
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_instr_queue.md
VECTOR_INSTR_QUEUE -- requirements
Module: vector_instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered vector instructions; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_vld_i  input  1  scalar core offers a vector instruction this cycle.
REQ-005 SHALL have port vector_instr_i  input  32  raw vector instruction word from scalar core.
REQ-006 SHALL have port rs1_i  input  32  scalar rs1 value belonging to the offered instruction.
REQ-007 SHALL have port rs2_i  input  32  scalar rs2 value belonging to the offered instruction.
REQ-008 SHALL have port sew_i  input  2  current SEW belonging to the offered instruction.
REQ-009 SHALL have port instr_rdy_o  output  1  queue accepts the offer this cycle.
REQ-010 SHALL have port vector_instr_o  output  32  head instruction to scheduler.
REQ-011 SHALL have port rs1_o  output  32  head rs1 to scheduler.
REQ-012 SHALL have port rs2_o  output  32  head rs2 to scheduler.
REQ-013 SHALL have port sew_o  output  2  head SEW to scheduler.
REQ-014 SHALL have port vector_stall_i  input  1  scheduler cannot consume head this cycle.
REQ-015 SHALL have port occupancy_o  output  $clog2(DEPTH)+1  stored entry count.
REQ-016 SHALL have port empty_o  output  1  occupancy_o == 0.
REQ-017 SHALL have port full_o  output  1  occupancy_o == DEPTH.

Function
REQ-018 SHALL push {vector_instr_i, rs1_i, rs2_i, sew_i} as one entry when instr_vld_i && instr_rdy_o.
REQ-019 SHALL drive instr_rdy_o = !full_o, registered-state only; no combinational path from vector_stall_i.
REQ-020 SHALL present head entry on vector_instr_o/rs1_o/rs2_o/sew_o whenever !empty_o; all four fields of one entry, never mixed.
REQ-021 SHALL drive vector_instr_o = 32'h0, rs1_o = rs2_o = 32'h0, sew_o = 2'b00 while empty_o (opcode 0 = no vector instruction to scheduler).
REQ-022 SHALL pop head on a rising edge iff !empty_o && !vector_stall_i.
REQ-023 SHALL hold head fields stable while vector_stall_i is high.
REQ-024 Push-to-head latency SHALL be exactly 1 cycle when empty (no same-cycle bypass).
REQ-025 Simultaneous push and pop with 0 < occupancy < DEPTH SHALL leave occupancy unchanged and preserve order.
REQ-026 When full, push SHALL be blocked even if a pop occurs that cycle; occupancy decrements to DEPTH-1.
REQ-027 When empty, vector_stall_i SHALL be ignored; no underflow.
REQ-028 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-029 occupancy_o SHALL be a registered counter: +1 on push only, -1 on pop only, unchanged otherwise.
REQ-030 Strict FIFO order SHALL be maintained; no reordering, no drop, no duplication.

Reset
REQ-031 On rstn low, SHALL asynchronously clear pointers and occupancy to 0; empty_o = 1, full_o = 0, instr_rdy_o = 1, head outputs all zero.
REQ-032 Reset mid-operation SHALL discard all buffered entries; storage array contents need not be cleared.
REQ-033 First push SHALL be accepted on the first rising edge with rstn high.

Structure
REQ-034 The entry record (instr, rs1, rs2, sew) typedef and default DEPTH constant SHALL live in typedef_pkg.
REQ-035 Storage SHALL be one sub-module, vector_instr_fifo_mem (DEPTH x 98-bit, 1 write port, 1 async read port).
REQ-036 Pointer/counter control SHALL stay in vector_instr_queue.

Verification
REQ-037 Reset, no stimulus -> empty_o=1, instr_rdy_o=1, vector_instr_o=32'h0, occupancy_o=0.
REQ-038 Push instr 32'h0205_7007 rs1=32'h1000 sew=2'b10 into empty queue, stall=0 -> appears at head next cycle, popped following edge, empty_o=1 again.
REQ-039 Stall=1, push 5 entries with DEPTH=4 -> first 4 accepted, full_o=1, instr_rdy_o=0 on 5th; 5th accepted one cycle after stall drops and one pop occurs.
REQ-040 Occupancy 2, push and pop same cycle repeatedly over 10 cycles -> occupancy stays 2, output order equals input order across pointer wrap.
REQ-041 Occupancy 3, assert rstn low mid-cycle -> outputs zero immediately, occupancy_o=0; after release, new push 32'h0000_0057 appears at head with no stale data.
REQ-042 Random push/stall for 10k cycles against scoreboard -> in-order, lossless, no pop while empty, no push while full.
